// File: rtl/hermes_local_arbiter_pkg.sv
// hermes_local_arbiter_pkg: shared Hermes types and constants
package HermesPkg;
    localparam int PKT_CNT_W = 16;
    typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/hermes_rr_arbiter.sv
// hermes_rr_arbiter: combinational round-robin picker, ptr is the highest-priority index
module hermes_rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant
);
    always_comb begin
        grant = '0;
        // scan from lowest priority up so the requester nearest ptr is written last
        for (int i = N - 1; i >= 0; i--)
            grant = |(req & (N'(1) << ((int'(ptr) + i) % N))) ? N'(1) << ((int'(ptr) + i) % N) : grant;
    end
endmodule

// File: rtl/hermes_local_arbiter.sv
// hermes_local_arbiter: round-robin sharing of one Hermes router local port among N_REQ requesters
module hermes_local_arbiter
    import HermesPkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int FLIT_SIZE = 32
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [N_REQ-1:0]                    req_rx_i,
    input  logic [N_REQ-1:0]                    req_eop_i,
    input  logic [N_REQ-1:0][FLIT_SIZE-1:0]     req_data_i,
    output logic [N_REQ-1:0]                    req_credit_o,
    output logic                                tx_o,
    output logic                                eop_o,
    output logic [FLIT_SIZE-1:0]                data_o,
    input  logic                                credit_i,
    output logic [N_REQ-1:0]                    grant_o,
    output logic                                busy_o,
    output logic [N_REQ-1:0][PKT_CNT_W-1:0]     pkt_cnt_o
);
    localparam int PW = $clog2(N_REQ);
    state_t state_q, state_d;
    logic [N_REQ-1:0] grant_q, winner;
    logic [PW-1:0] ptr_q, owner;
    logic [N_REQ-1:0][PKT_CNT_W-1:0] cnt_q;
    logic eop_xfer;

    hermes_rr_arbiter #(.N(N_REQ)) u_rr (
        .req   (req_rx_i),
        .ptr   (ptr_q),
        .grant (winner)
    );

    always_comb begin
        owner = '0;
        for (int i = 0; i < N_REQ; i++)
            owner = grant_q[i] ? PW'(i) : owner;
    end

    assign eop_xfer = tx_o & credit_i & eop_o;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == IDLE) ? (|req_rx_i ? SEND : IDLE) : (eop_xfer ? IDLE : SEND);
    end

    always_comb begin
        busy_o       = state_q == SEND;
        tx_o         = busy_o & |(req_rx_i & grant_q);
        eop_o        = busy_o & |(req_eop_i & grant_q);
        data_o       = busy_o ? req_data_i[owner] : '0;
        req_credit_o = (busy_o && credit_i) ? grant_q : '0;
        grant_o      = grant_q;
        pkt_cnt_o    = cnt_q;
    end

    // grant is latched in IDLE and only released by the eop transfer, so packets are never preempted
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else if (state_q == IDLE) begin
            grant_q <= winner;
        end else if (eop_xfer) begin
            grant_q      <= '0;
            ptr_q        <= (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;
            cnt_q[owner] <= cnt_q[owner] + 1'b1;
        end
    end
endmodule

// File: tb/tb_hermes_local_arbiter.sv
// tb_hermes_local_arbiter: directed stimulus checked every cycle against a packet-level model
module tb_hermes_local_arbiter;
    localparam int N  = 4;
    localparam int FW = 32;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic [N-1:0] req_rx_i = '0;
    logic [N-1:0] req_eop_i = '0;
    logic [N-1:0][FW-1:0] req_data_i = '0;
    logic [N-1:0] req_credit_o;
    logic tx_o, eop_o, busy_o;
    logic credit_i = 1'b0;
    logic [FW-1:0] data_o;
    logic [N-1:0] grant_o;
    logic [N-1:0][15:0] pkt_cnt_o;

    int vectors = 0;
    int errors = 0;
    int rem[N];
    int seq[N];
    int plen[N];
    int refill[N];
    bit hold[N];
    bit acc[N];
    bit rst = 1'b1;
    bit cred = 1'b1;
    int m_owner = -1;
    int m_ptr = 0;
    int m_cnt[N];
    int log_q[$];
    int gq[$];
    int n_cyc, n_busy;

    hermes_local_arbiter #(.N_REQ(N), .FLIT_SIZE(FW)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_rx_i     (req_rx_i),
        .req_eop_i    (req_eop_i),
        .req_data_i   (req_data_i),
        .req_credit_o (req_credit_o),
        .tx_o         (tx_o),
        .eop_o        (eop_o),
        .data_o       (data_o),
        .credit_i     (credit_i),
        .grant_o      (grant_o),
        .busy_o       (busy_o),
        .pkt_cnt_o    (pkt_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic start(input int r, input int len);
        rem[r] = len;
        plen[r] = len;
        seq[r] = 0;
    endtask

    function automatic bit rem_any();
        foreach (rem[r])
            if (rem[r] > 0 || refill[r] > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        foreach (rem[r]) begin
            rem[r] = 0;
            refill[r] = 0;
            hold[r] = 1'b0;
        end
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic run_track(input int budget);
        logic [N-1:0] gprev = '0;
        gq.delete();
        n_cyc = 0;
        n_busy = 0;
        while ((busy_o || rem_any()) && n_cyc < budget) begin
            tick(1);
            n_cyc++;
            if (busy_o) n_busy++;
            if (grant_o != '0 && grant_o != gprev) gq.push_back(int'(grant_o));
            gprev = grant_o;
        end
        check("run_bound", 64'(n_cyc < budget), 64'd1);
    endtask

    // Requester behaviour: present flits in order, advance only on an accepted flit
    always @(posedge clk) begin
        #1;
        for (int r = 0; r < N; r++) begin
            if (acc[r] && rem[r] > 0) begin
                rem[r]--;
                seq[r]++;
                if (rem[r] == 0 && refill[r] > 0) begin
                    rem[r] = plen[r];
                    seq[r] = 0;
                    refill[r]--;
                end
            end
            req_rx_i[r]   = rem[r] > 0 && !hold[r];
            req_eop_i[r]  = req_rx_i[r] && rem[r] == 1;
            req_data_i[r] = FW'(r * 65536 + seq[r]);
        end
        credit_i = cred;
        rst_i = rst;
    end

    // Packet-level reference: owner index, priority pointer, per-requester counts
    always @(negedge clk) begin
        logic [63:0] ecnt;
        int o;
        o = m_owner;
        ecnt = '0;
        for (int r = 0; r < N; r++) ecnt[r*16 +: 16] = 16'(m_cnt[r]);
        check("tx_o", 64'(tx_o), o < 0 ? 64'd0 : 64'(req_rx_i[o]));
        check("eop_o", 64'(eop_o), o < 0 ? 64'd0 : 64'(req_eop_i[o]));
        check("data_o", 64'(data_o), o < 0 ? 64'd0 : 64'(req_data_i[o]));
        check("req_credit_o", 64'(req_credit_o), (o < 0 || !credit_i) ? 64'd0 : 64'd1 << o);
        check("grant_o", 64'(grant_o), o < 0 ? 64'd0 : 64'd1 << o);
        check("busy_o", 64'(busy_o), o < 0 ? 64'd0 : 64'd1);
        check("pkt_cnt_o", 64'(pkt_cnt_o), ecnt);
        for (int r = 0; r < N; r++) acc[r] = req_rx_i[r] & req_credit_o[r];
        if (rst_i) begin
            m_owner = -1;
            m_ptr = 0;
            foreach (m_cnt[r]) m_cnt[r] = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++)
                if (m_owner < 0 && req_rx_i[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
            if (m_owner >= 0) log_q.push_back(m_owner);
        end else if (req_rx_i[m_owner] && credit_i && req_eop_i[m_owner]) begin
            m_cnt[m_owner] = (m_cnt[m_owner] + 1) % 65536;
            m_ptr = (m_owner + 1) % N;
            m_owner = -1;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(2);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_grant", 64'(grant_o), 64'd0);
        check("rst_tx", 64'(tx_o), 64'd0);
        rst = 1'b0;
        tick(1);
        // single requester, 3-flit packet
        start(2, 3);
        tick(2);
        check("single_grant", 64'(grant_o), 64'h4);
        check("single_tx0", 64'(tx_o), 64'd1);
        repeat (2) begin
            tick(1);
            check("single_txn", 64'(tx_o), 64'd1);
        end
        tick(1);
        check("single_busy_end", 64'(busy_o), 64'd0);
        check("single_cnt", 64'(pkt_cnt_o[2]), 64'd1);
        check("model_single_cnt", 64'(m_cnt[2]), 64'd1);
        // contention from reset: 0,1,2,3 with one idle cycle between packets
        do_reset();
        log_q.delete();
        for (int r = 0; r < N; r++) start(r, 2);
        run_track(100);
        check("cont_order_len", 64'(gq.size()), 64'd4);
        for (int i = 0; i < 4 && i < gq.size(); i++) check("cont_order", 64'(gq[i]), 64'd1 << i);
        check("model_order", 64'((log_q.size() == 4) ? {log_q[0][1:0], log_q[1][1:0], log_q[2][1:0], log_q[3][1:0]} : 8'hFF), 64'h1B);
        check("cont_busy_cycles", 64'(n_busy), 64'd8);
        check("cont_span", 64'(n_cyc), 64'd13);
        check("cont_cnt", 64'(pkt_cnt_o), 64'h0001_0001_0001_0001);
        // back-pressure on flit 1 of a 4-flit packet
        start(1, 4);
        tick(2);
        cred = 1'b0;
        repeat (5) begin
            tick(1);
            check("bp_data", 64'(data_o), 64'h0001_0001);
            check("bp_eop", 64'(eop_o), 64'd0);
            check("bp_credit", 64'(req_credit_o), 64'd0);
            check("bp_grant", 64'(grant_o), 64'h2);
        end
        check("bp_cnt_hold", 64'(pkt_cnt_o), 64'h0001_0001_0001_0001);
        cred = 1'b1;
        run_track(30);
        check("bp_cnt", 64'(pkt_cnt_o), 64'h0001_0001_0002_0001);
        // owner stall and non-preemption; ptr=2 so req3 beats req0
        start(1, 4);
        tick(2);
        start(0, 1);
        start(3, 1);
        hold[1] = 1'b1;
        repeat (2) begin
            tick(1);
            check("stall_tx", 64'(tx_o), 64'd0);
            check("stall_grant", 64'(grant_o), 64'h2);
        end
        hold[1] = 1'b0;
        run_track(60);
        check("np_order_len", 64'(gq.size()), 64'd3);
        if (gq.size() == 3) begin
            check("np_first", 64'(gq[0]), 64'h2);
            check("np_second", 64'(gq[1]), 64'h8);
            check("np_third", 64'(gq[2]), 64'h1);
        end
        check("np_cnt", 64'(pkt_cnt_o), 64'h0002_0001_0003_0002);
        // reset during flit 2 of 4; ptr was 1, so a fresh 0+1 request shows whether ptr cleared
        start(2, 4);
        tick(3);
        rst = 1'b1;
        foreach (rem[r]) rem[r] = 0;
        tick(2);
        check("mrst_tx", 64'(tx_o), 64'd0);
        check("mrst_grant", 64'(grant_o), 64'd0);
        check("mrst_busy", 64'(busy_o), 64'd0);
        check("mrst_cnt", 64'(pkt_cnt_o), 64'd0);
        rst = 1'b0;
        tick(1);
        start(0, 1);
        start(1, 1);
        tick(2);
        check("mrst_fresh_grant", 64'(grant_o), 64'h1);
        run_track(30);
        check("mrst_fresh_cnt", 64'(pkt_cnt_o), 64'h0000_0000_0001_0001);
        // 65536 single-flit packets from req3 wrap its counter to zero
        refill[3] = 65535;
        start(3, 1);
        run_track(140000);
        check("wrap_busy_cycles", 64'(n_busy), 64'd65536);
        check("wrap_cnt", 64'(pkt_cnt_o), 64'h0000_0000_0001_0001);
        check("model_wrap_cnt", 64'(m_cnt[3]), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
